pu_div_seq: RTL
===============

PU_DIV_SEQ -- requirements
Module: pu_div_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter ATTR_WIDTH, default 4: attribute bus width.
REQ-003 SHALL have parameter INVALID, default 0: bit index of the invalid flag within attr.
REQ-004 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have parameter FRAC, default 0: fixed-point fraction bits; the dividend is the numerator shifted left by FRAC.
REQ-006 SHALL have parameter RESULT_DEPTH, default 2 (min 1): result FIFO entries.
REQ-007 SHALL have port clk, input, 1: clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port signal_wr, input, 1: operand write strobe.
REQ-010 SHALL have port signal_wr_sel, input, 1: 0 = numerator, 1 = denominator (launches op).
REQ-011 SHALL have port data_in, input, DATA_WIDTH: operand value.
REQ-012 SHALL have port attr_in, input, ATTR_WIDTH: operand attributes; only bit INVALID is used.
REQ-013 SHALL have port signal_oe, input, 1: result output enable.
REQ-014 SHALL have port signal_oe_sel, input, 1: 0 = quotient, 1 = remainder.
REQ-015 SHALL have port data_out, output, DATA_WIDTH: FIFO-head result, 0 when signal_oe=0.
REQ-016 SHALL have port attr_out, output, ATTR_WIDTH: head invalid flag at bit INVALID, other bits 0; all 0 when signal_oe=0.
REQ-017 SHALL have port busy, output, 1: engine or pending slot occupied.
REQ-018 SHALL have port full, output, 1: pending slot occupied; the next launch is dropped.
REQ-019 SHALL have port overrun, output, 1: sticky, set when a launch is dropped.

Function
REQ-020 Numerator write (wr=1, sel=0) SHALL latch data_in and attr_in[INVALID]; the latch holds until overwritten.
REQ-021 Denominator write (wr=1, sel=1) SHALL form an op {latched numerator, data_in, invalid = latched attr | attr_in[INVALID]}.
REQ-022 The op SHALL load the engine on the same edge iff the engine is idle, the pending slot is empty and fifo_count < RESULT_DEPTH; otherwise it goes to the pending slot if empty; otherwise it is dropped and overrun set.
REQ-023 The pending op SHALL load the engine on the first edge where the engine is idle and fifo_count + 1 <= RESULT_DEPTH, counting a same-edge pop.
REQ-024 The engine SHALL be a radix-2 restoring divider on magnitudes, N = DATA_WIDTH+FRAC iterations, one per cycle.
REQ-025 The result SHALL be pushed into the FIFO on the edge after the last iteration; the head is visible N+2 cycles after the launching write edge when loaded directly.
REQ-026 Signed mode SHALL truncate toward zero: quotient sign = XOR of operand signs, remainder sign = numerator sign.
REQ-027 The quotient SHALL be the low DATA_WIDTH bits; nonzero discarded high bits, or a signed result out of range (e.g. MIN / -1), SHALL set invalid, with quotient = truncated value (MIN for MIN / -1).
REQ-028 Denominator 0 SHALL give quotient 0, remainder = numerator and invalid 1, with unchanged latency N+2.
REQ-029 A read transaction is one or more consecutive cycles with signal_oe=1; the head SHALL be popped on the edge ending the last such cycle (signal_oe high now, low next cycle).
REQ-030 During a read, data_out/attr_out SHALL be combinational from the head entry; quotient and remainder are both readable within one transaction.
REQ-031 A read with an empty FIFO SHALL give data_out 0 and invalid 1, and pop nothing.
REQ-032 A simultaneous FIFO push and pop SHALL both take effect, with count unchanged.
REQ-033 Operand writes SHALL be accepted during a read or while the engine is busy.

Reset
REQ-034 rst SHALL clear the numerator latch, the engine (idle), the pending slot, the FIFO (count 0) and overrun, and abort any in-flight op without pushing.
REQ-035 While rst=1, busy, full and overrun SHALL be 0; data_out and attr_out SHALL follow REQ-015/016/031.

Verification (DATA_WIDTH=8, SIGNED=1, FRAC=0, RESULT_DEPTH=2 unless noted)
REQ-036 100 / 7 -> quotient 0x0E, remainder 0x02, invalid 0, readable 10 cycles after the denominator write.
REQ-037 -100 / 7 -> quotient 0xF2, remainder 0xFE; -128 / -1 -> quotient 0x80, invalid 1; 5 / 0 -> quotient 0, remainder 5, invalid 1.
REQ-038 SIGNED=0, FRAC=4: 3 / 2 -> quotient 0x18; 0x20 / 1 -> invalid 1.
REQ-039 Four back-to-back launches, no reads -> ops 1-2 fill the FIFO and op 3 sits pending (full=1, busy=1), op 4 is dropped with overrun=1; then three read transactions return ops 1, 2, 3 in order, with op 3 starting only after the first pop.
REQ-040 rst asserted 3 cycles into an op -> after release the FIFO is empty, a read gives data 0 / invalid 1, and overrun=0.

Source files
------------

// File: rtl/pu_div_seq.sv
// Sequential radix-2 restoring divider: operand latch, one pending-op slot
// and a small result FIFO drained through a read-strobe interface.
module pu_div_seq #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ATTR_WIDTH   = 4,
    parameter int unsigned INVALID      = 0,
    parameter int unsigned SIGNED       = 1,
    parameter int unsigned FRAC         = 0,
    parameter int unsigned RESULT_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_wr,
    input  logic                  signal_wr_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    input  logic                  signal_oe_sel,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  busy,
    output logic                  full,
    output logic                  overrun
);
    localparam int unsigned W      = DATA_WIDTH;
    localparam int unsigned N      = DATA_WIDTH + FRAC;
    localparam int unsigned ITER_W = $clog2(N + 1);
    localparam int unsigned PTR_W  = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(RESULT_DEPTH + 1);

    typedef enum logic [1:0] {ENG_IDLE, ENG_PREP, ENG_CALC, ENG_DONE} eng_state_t;

    typedef struct packed {
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic         inv;
    } op_t;

    typedef struct packed {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         inv;
    } res_t;

    eng_state_t        state_q, state_d;
    op_t               op_q, op_d, pend_q, pend_d, new_op;
    logic              pend_vld_q, pend_vld_d;
    logic [W-1:0]      num_lat_q, num_lat_d;
    logic              num_inv_q, num_inv_d;
    logic              num_neg_q, num_neg_d, den_neg_q, den_neg_d;
    logic [W-1:0]      den_mag_q, den_mag_d, rem_q, rem_d;
    logic [N-1:0]      quo_q, quo_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              oe_q, overrun_q, overrun_d;
    res_t              fifo_q [RESULT_DEPTH];
    res_t              res, head;

    logic              launch, direct, pend_load, push, pop, empty;
    logic [W-1:0]      num_mag, den_mag_n, rem_s;
    logic [W:0]        trial, diff;
    logic [N-1:0]      q_signed, lim;
    logic              q_neg, ovf;

    // Result formatting from the finished engine registers
    always_comb begin
        q_neg    = num_neg_q ^ den_neg_q;
        q_signed = q_neg ? (-quo_q) : quo_q;
        lim      = '0;
        if (SIGNED != 0) begin
            lim[W-2:0] = '1;
            lim        = lim + N'(q_neg);
        end else begin
            lim[W-1:0] = '1;
        end
        ovf   = (quo_q > lim);
        rem_s = num_neg_q ? (-rem_q) : rem_q;
        res   = '{quo: q_signed[W-1:0], rem: rem_s, inv: op_q.inv | ovf};
        if (den_mag_q == '0) begin
            res = '{quo: '0, rem: op_q.num, inv: 1'b1};
        end
    end

    always_comb begin
        launch    = signal_wr && signal_wr_sel;
        new_op    = '{num: num_lat_q, den: data_in, inv: num_inv_q | attr_in[INVALID]};
        push      = (state_q == ENG_DONE);
        pop       = oe_q && !signal_oe && (count_q != '0);
        direct    = launch && (state_q == ENG_IDLE) && !pend_vld_q &&
                    (count_q < CNT_W'(RESULT_DEPTH));
        // A pending op may reuse the slot freed by a pop on the same edge
        pend_load = (state_q == ENG_IDLE) && pend_vld_q &&
                    ((count_q - CNT_W'(pop)) < CNT_W'(RESULT_DEPTH));

        num_lat_d  = num_lat_q;
        num_inv_d  = num_inv_q;
        state_d    = state_q;
        op_d       = op_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overrun_d  = overrun_q;
        num_neg_d  = num_neg_q;
        den_neg_d  = den_neg_q;
        den_mag_d  = den_mag_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        iter_d     = iter_q;
        num_mag    = '0;
        den_mag_n  = '0;
        trial      = '0;
        diff       = '0;

        if (signal_wr && !signal_wr_sel) begin
            num_lat_d = data_in;
            num_inv_d = attr_in[INVALID];
        end

        if (pend_load) begin
            pend_vld_d = 1'b0;
        end
        if (launch && !direct) begin
            if (!pend_vld_q) begin
                pend_vld_d = 1'b1;
                pend_d     = new_op;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            ENG_IDLE: begin
                if (pend_load) begin
                    op_d    = pend_q;
                    state_d = ENG_PREP;
                end else if (direct) begin
                    op_d    = new_op;
                    state_d = ENG_PREP;
                end
            end
            ENG_PREP: begin
                num_neg_d = (SIGNED != 0) && op_q.num[W-1];
                den_neg_d = (SIGNED != 0) && op_q.den[W-1];
                num_mag   = num_neg_d ? (-op_q.num) : op_q.num;
                den_mag_n = den_neg_d ? (-op_q.den) : op_q.den;
                den_mag_d = den_mag_n;
                quo_d     = N'(num_mag) << FRAC;
                rem_d     = '0;
                iter_d    = '0;
                state_d   = ENG_CALC;
            end
            ENG_CALC: begin
                trial = {rem_q, quo_q[N-1]};
                diff  = trial - {1'b0, den_mag_q};
                if (trial >= {1'b0, den_mag_q}) begin
                    rem_d = diff[W-1:0];
                    quo_d = {quo_q[N-2:0], 1'b1};
                end else begin
                    rem_d = trial[W-1:0];
                    quo_d = {quo_q[N-2:0], 1'b0};
                end
                iter_d = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(N - 1)) begin
                    state_d = ENG_DONE;
                end
            end
            ENG_DONE: state_d = ENG_IDLE;
            default:  state_d = ENG_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RESULT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RESULT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENG_IDLE;
            op_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            num_lat_q  <= '0;
            num_inv_q  <= 1'b0;
            num_neg_q  <= 1'b0;
            den_neg_q  <= 1'b0;
            den_mag_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            iter_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            oe_q       <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            num_lat_q  <= num_lat_d;
            num_inv_q  <= num_inv_d;
            num_neg_q  <= num_neg_d;
            den_neg_q  <= den_neg_d;
            den_mag_q  <= den_mag_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            iter_q     <= iter_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            oe_q       <= signal_oe;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= res;
        end
    end

    always_comb begin
        head     = fifo_q[rd_ptr_q];
        empty    = rst || (count_q == '0);
        data_out = '0;
        attr_out = '0;
        if (signal_oe) begin
            if (empty) begin
                attr_out[INVALID] = 1'b1;
            end else begin
                data_out          = signal_oe_sel ? head.rem : head.quo;
                attr_out[INVALID] = head.inv;
            end
        end
    end

    assign busy    = !rst && ((state_q != ENG_IDLE) || pend_vld_q);
    assign full    = !rst && pend_vld_q;
    assign overrun = !rst && overrun_q;

endmodule
